// File: rtl/pwm_multicanal.sv
// pwm_multicanal: multi-channel PWM generator sharing one period counter.
// A programmable prescaler sets the step rate. Edge- and center-aligned modes are supported.
// Duty values are double-buffered and take effect only at a period start.
module pwm_multicanal #(
    parameter int N_CANALES   = 4,
    parameter int ANCHO       = 4,
    parameter int ANCHO_PRESC = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         habilitar,
    input  logic                         modo,
    input  logic [ANCHO_PRESC-1:0]       divisor,
    input  logic [N_CANALES*ANCHO-1:0]   ciclo_trabajo,
    input  logic                         cargar,
    output logic [N_CANALES-1:0]         salidaPWM,
    output logic                         inicio_periodo,
    output logic                         pendiente
);

    logic [ANCHO_PRESC-1:0]             presc;
    logic [ANCHO:0]                     contador;
    logic [ANCHO:0]                     contador_sig;
    logic [N_CANALES-1:0][ANCHO-1:0]    activo;
    logic [N_CANALES-1:0][ANCHO-1:0]    sombra;
    logic [N_CANALES-1:0][ANCHO-1:0]    activo_sig;
    logic [ANCHO-1:0]                   cmp_sig;
    logic [N_CANALES-1:0]               pwm_sig;
    logic                               modo_activo;
    logic                               corriendo;
    logic                               tick;
    logic                               fin_periodo;
    logic                               inicio;
    logic                               avanza;

    // Next counter value, period-start detection and next PWM levels
    always_comb begin
        tick         = (presc >= divisor);
        fin_periodo  = modo_activo ? (&contador) : (&contador[ANCHO-1:0]);
        contador_sig = contador;
        inicio       = 1'b0;
        avanza       = 1'b0;
        // The first enabled clock after idle or reset counts as a period start
        if (!corriendo) begin
            contador_sig = '0;
            inicio       = 1'b1;
            avanza       = 1'b1;
        end else if (tick) begin
            contador_sig = fin_periodo ? '0 : contador + 1'b1;
            inicio       = fin_periodo;
            avanza       = 1'b1;
        end
        activo_sig = (inicio && pendiente) ? sombra : activo;
        cmp_sig    = (modo_activo && contador_sig[ANCHO]) ? ~contador_sig[ANCHO-1:0]
                                                           : contador_sig[ANCHO-1:0];
        for (int unsigned i = 0; i < N_CANALES; i++) begin
            pwm_sig[i] = (cmp_sig < activo_sig[i]);
        end
    end

    // Prescaler, period counter, double buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc          <= '0;
            contador       <= '0;
            activo         <= '0;
            sombra         <= '0;
            modo_activo    <= 1'b0;
            corriendo      <= 1'b0;
            salidaPWM      <= '0;
            inicio_periodo <= 1'b0;
            pendiente      <= 1'b0;
        end else begin
            if (!habilitar) begin
                presc          <= '0;
                contador       <= '0;
                corriendo      <= 1'b0;
                salidaPWM      <= '0;
                inicio_periodo <= 1'b0;
            end else begin
                corriendo      <= 1'b1;
                presc          <= avanza ? '0 : presc + 1'b1;
                contador       <= contador_sig;
                inicio_periodo <= inicio;
                if (avanza) begin
                    salidaPWM <= pwm_sig;
                end
                if (inicio) begin
                    activo      <= activo_sig;
                    modo_activo <= modo;
                end
            end
            // A load coinciding with a period start refills the shadow after the old one is applied
            if (cargar) begin
                sombra    <= ciclo_trabajo;
                pendiente <= 1'b1;
            end else if (habilitar && inicio && pendiente) begin
                pendiente <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pwm_multicanal.md
# pwm_multicanal

Parametrised multi-channel PWM generator, successor to the single-channel 4-bit switch-driven PWM block. It drives `N_CANALES` independent outputs from one shared period counter with a programmable clock prescaler, and supports edge-aligned or center-aligned modes. Duty cycles are double-buffered so an update never corrupts a period in progress. It sits between the user-I/O register layer (switches/bus) and LED/motor-driver pins. The system clock is 27 MHz.

## Interface
- `N_CANALES`, default 4: number of PWM channels.
- `ANCHO`, default 4: duty/counter resolution in bits; one period spans 2^ANCHO steps.
- `ANCHO_PRESC`, default 8: prescaler divisor width.

- `clk`  in  1  system clock, 27 MHz. The block uses one clock; every register is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `habilitar`  in  1  run enable.
- `modo`  in  1  0 = edge-aligned, 1 = center-aligned.
- `divisor`  in  ANCHO_PRESC  a counter step occurs every `divisor`+1 clocks.
- `ciclo_trabajo`  in  N_CANALES*ANCHO  duty per channel; channel i is bits [i*ANCHO +: ANCHO].
- `cargar`  in  1  one-clock strobe that latches `ciclo_trabajo` into the shadow register.
- `salidaPWM`  out  N_CANALES  PWM outputs, registered.
- `inicio_periodo`  out  1  one-clock pulse at each period start, registered.
- `pendiente`  out  1  shadow holds a load not yet applied.

## Operation
- **Prescaler.** `presc` counts clocks while `habilitar`=1. `tick` is asserted when `presc >= divisor`, and `presc` then returns to 0. The `>=` compare keeps a live decrease of `divisor` safe.
- **Period counter.** `contador` is ANCHO+1 bits and advances by 1 per tick.
  - Edge mode: it wraps at 2^ANCHO−1, so period = 2^ANCHO ticks, and `cmp = contador[ANCHO-1:0]`.
  - Center mode: it wraps at 2^(ANCHO+1)−1, so period = 2^(ANCHO+1) ticks. `fase = contador[ANCHO]`, and `cmp = fase ? ~contador[ANCHO-1:0] : contador[ANCHO-1:0]`. `cmp` therefore counts up from 0 to max and back down to 0.
- **Output.** `salidaPWM[i] = (cmp < activo[i])`.
  - Duty is activo/2^ANCHO in both modes.
  - Duty 0 gives constant 0. The maximum duty is (2^ANCHO−1)/2^ANCHO.
  - In center mode the high interval is centred on the period boundary.
- **Double buffer.**
  - `cargar`=1 writes `ciclo_trabajo` to `sombra` and sets `pendiente`.
  - At each period start (the tick that wraps `contador` to 0), if `pendiente`=1, `activo <= sombra` and `pendiente` clears.
  - `modo` is sampled into `modo_activo` only at period start.
- **Simultaneous `cargar` and period start.** The old `sombra` transfers to `activo`, the new data enters `sombra`, and `pendiente` stays 1.
- **Disable.** When `habilitar`=0:
  - `presc` and `contador` clear to 0, `salidaPWM` is 0 and `inicio_periodo` is 0.
  - `cargar` is still accepted.
  - On re-enable, the first clock is a period start: `inicio_periodo`=1, the pending shadow is applied and `modo` is sampled.
- **Reset** (`rst`=1 for any clock, including mid-period): `presc`, `contador`, `activo`, `sombra` and `modo_activo` go to 0. All outputs go to 0: `salidaPWM`, `inicio_periodo`, `pendiente`.

## Timing
- Every output is a flop; there is no combinational input→output path.
- On the edge where a tick moves `contador` to value c, the same edge loads `salidaPWM` from cmp(c) and the new `activo`. The output has no extra clock of lag relative to the counter.
- `inicio_periodo` is high for exactly one clock, on the edge that enters `contador`=0.
- With `divisor`=D, one tick occurs every D+1 clocks.
  - Edge-mode period = 2^ANCHO·(D+1) clocks.
  - Center-mode period = 2^(ANCHO+1)·(D+1) clocks.
- A `cargar` at clock t:
  - `pendiente` is visible at t+1.
  - The new duty takes effect at the next period start, never earlier.
- `rst` has priority over `habilitar` and `cargar`.

## Test plan
Unless stated, all cases use ANCHO=4, N_CANALES=2, D=0 and edge mode.

- **Basic duty.** Load duties {0, 4} then enable. Ch0 stays 0. Ch1 is high 4 clocks of every 16. `inicio_periodo` pulses every 16 clocks.
- **Prescaler and max duty.** Load duty 15, D=2. Ch high 45 clocks of every 48. Then change D to 0 mid-count: `presc` wraps immediately with no hang.
- **Center mode.** Set `modo`=1 and duty 4. Period is 32 clocks. Output is high for 8 contiguous clocks: 4 before and 4 after each `inicio_periodo`.
- **Mid-period reload.** Load duty 4, then duty 12 at clock 5 of a period. The current period keeps 4-high. The next period is 12-high. `pendiente` reads 1 from clock 6 until the period start.
- **Simultaneous load at boundary.** Issue `cargar` on the boundary edge. The old shadow is applied, the new value waits, `pendiente`=1, and the new value is applied one period later.
- **Reset and disable mid-period.** Assert `rst` at clock 7 of a period: all outputs go to 0 next clock and `activo` clears. Deassert `habilitar` mid-period: outputs go to 0. Re-enable: `inicio_periodo` fires on the first clock.
